pc_incrementer: RTL and testbench
=================================

// Module: pc_incrementer
//
// PURPOSE
// Registered, parametrised successor to the combinational INCR block.
// Holds the program counter and advances it each clock by STEP, or by 2*STEP when skip is asserted.
// Supports a stall, a branch/jump load and a choice of wrap or saturate at the top of the address space.
// Sits in the fetch stage and feeds the instruction-memory address and the PC+STEP link value.
//
// PARAMETERS
// WIDTH      32  counter / address width in bits (>=4)
// STEP        4  normal increment (bytes per instruction); 1..2^(WIDTH-2)
// RESET_VAL   0  value loaded into pc on reset
// SAT_MODE    0  0 = wrap modulo 2^WIDTH; 1 = saturate (hold) on overflow
//
// PORTS
// clk        in   1      system clock, all state on rising edge
// reset      in   1      synchronous, active-high reset
// stall      in   1      1 = hold pc this cycle (ignored when load=1)
// skip       in   1      1 = advance by 2*STEP instead of STEP
// load       in   1      1 = pc <= load_addr next edge (branch/jump)
// load_addr  in   WIDTH  target address for load
// pc         out  WIDTH  current program counter (registered)
// pc_plus    out  WIDTH  pc + STEP mod 2^WIDTH, combinational from pc (link value)
// wrap       out  1      registered 1-cycle pulse: last advance carried out of WIDTH
// sat        out  1      sticky: counter hit overflow in SAT_MODE=1 and is frozen
//
// BEHAVIOUR
// - Reset values: pc=RESET_VAL, wrap=0, sat=0. pc_plus=RESET_VAL+STEP one delta later.
// - Per-edge priority: reset > load > sat-freeze > stall > advance.
// - load: pc<=load_addr (unaligned values accepted as-is), wrap<=0, sat<=0.
//   Load overrides stall and releases saturation. skip is ignored on a load cycle.
// - Freeze: when sat=1 and load=0, pc holds and wrap<=0, regardless of stall/skip.
// - stall (no load, no sat): pc holds, wrap<=0.
// - Advance: inc = skip ? 2*STEP : STEP. The sum is computed at WIDTH+1 bits as {c,s} = pc + inc.
//   - c=0: pc<=s, wrap<=0.
//   - c=1, SAT_MODE=0: pc<=s (modulo), wrap<=1 for exactly one cycle.
//   - c=1, SAT_MODE=1: pc holds its old value, sat<=1, wrap<=1 for one cycle. Freeze applies from the next edge.
// - Latency: one clock from the input sampled to the pc update. pc_plus has zero latency relative to pc.
// - No internal state beyond pc, wrap and sat; there is no pending-load queue.
// - Reset mid-stall, mid-load or while saturated: reset wins and clears all flags.
// - pc_plus never saturates; it always wraps modulo 2^WIDTH, even in SAT_MODE=1.
//
// TESTING (WIDTH=32, STEP=4 unless stated)
// 1 reset=1 for 2 clks, then release with stall=0 -> pc=0,4,8,12 on successive edges; pc_plus=pc+4; wrap=0, sat=0.
// 2 At pc=8: stall=1 for 3 clks -> pc stays 8. Then stall=1 & load=1, load_addr=0x100
//   -> pc=0x100. Next clk with no controls -> pc=0x104.
// 3 At pc=0x104: skip=1 for 1 clk -> pc=0x10C. skip=1 & stall=1 -> pc stays 0x10C.
// 4 SAT_MODE=0: load 0xFFFFFFF8, advance 2 clks -> pc=0xFFFFFFFC then 0x00000000.
//   wrap=1 only in the cycle pc=0, else 0; pc_plus at 0xFFFFFFFC is 0.
// 5 SAT_MODE=1: load 0xFFFFFFFC, advance -> pc stays 0xFFFFFFFC, sat=1, wrap pulses once.
//   Stall/skip have no effect while saturated. load 0x40 -> pc=0x40, sat=0, then 0x44.
// 6 reset asserted while sat=1 and load=1 simultaneously -> pc=RESET_VAL, sat=0, wrap=0 next edge.

Source files
------------

// File: rtl/pc_incrementer_if.sv
// Fetch-control bundle between the fetch sequencer and the PC register.
// No valid/ready handshake here: every control input is sampled on each rising clk edge and every output is valid in every cycle.
interface pc_incrementer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             skip;
    logic             load;
    logic [WIDTH-1:0] load_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             wrap;
    logic             sat;

    modport master (
        output stall, skip, load, load_addr,
        input  pc, pc_plus, wrap, sat
    );

    modport slave (
        input  stall, skip, load, load_addr,
        output pc, pc_plus, wrap, sat
    );
endinterface

// File: rtl/pc_incrementer.sv
// Registered program counter for the fetch stage.
// Advances by STEP or 2*STEP, with stall, branch load and wrap/saturate handling at the top of the address space.
module pc_incrementer #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SAT_MODE  = 1'b0
) (
    input logic             clk,
    input logic             reset,
    pc_incrementer_if.slave bus
);
    localparam logic [WIDTH:0]   INC_ONE = (WIDTH+1)'(longint'(STEP));
    localparam logic [WIDTH:0]   INC_TWO = (WIDTH+1)'(2 * longint'(STEP));
    localparam logic [WIDTH-1:0] LINK    = WIDTH'(longint'(STEP));

    logic [WIDTH-1:0] pcReg;
    logic             wrapReg;
    logic             satReg;
    logic [WIDTH:0]   nextSum;

    // The extra top bit is the carry out of WIDTH that drives wrap/sat.
    always_comb begin
        nextSum = {1'b0, pcReg} + (bus.skip ? INC_TWO : INC_ONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg   <= RESET_VAL;
            wrapReg <= 1'b0;
            satReg  <= 1'b0;
        end else if (bus.load) begin
            pcReg   <= bus.load_addr;
            wrapReg <= 1'b0;
            satReg  <= 1'b0;
        end else if (satReg) begin
            wrapReg <= 1'b0;
        end else if (bus.stall) begin
            wrapReg <= 1'b0;
        end else if (nextSum[WIDTH]) begin
            wrapReg <= 1'b1;
            if (SAT_MODE) begin
                satReg <= 1'b1;
            end else begin
                pcReg <= nextSum[WIDTH-1:0];
            end
        end else begin
            pcReg   <= nextSum[WIDTH-1:0];
            wrapReg <= 1'b0;
        end
    end

    // Link value always wraps, even when the counter itself is saturating.
    assign bus.pc_plus = pcReg + LINK;
    assign bus.pc      = pcReg;
    assign bus.wrap    = wrapReg;
    assign bus.sat     = satReg;
endmodule

// File: tb/tb_pc_incrementer.sv
// Bench for pc_incrementer: one wrap-mode and one saturate-mode instance driven with identical stimulus.
// Expected {pc, pc_plus, wrap, sat} per cycle is queued when stimulus is driven and compared after the edge.
module tb_pc_incrementer;
    logic clk;
    logic reset;
    logic stall;
    logic skip;
    logic load;
    logic [31:0] load_addr;

    logic [65:0] exp0_q[$];
    logic [65:0] exp1_q[$];
    logic [65:0] e0, e1, o0, o1;
    int n_cmp;
    int n_fail;

    pc_incrementer_if #(.WIDTH(32)) bus0 ();
    pc_incrementer_if #(.WIDTH(32)) bus1 ();

    assign bus0.stall     = stall;
    assign bus0.skip      = skip;
    assign bus0.load      = load;
    assign bus0.load_addr = load_addr;
    assign bus1.stall     = stall;
    assign bus1.skip      = skip;
    assign bus1.load      = load;
    assign bus1.load_addr = load_addr;

    pc_incrementer #(.WIDTH(32), .STEP(4), .RESET_VAL(32'h0), .SAT_MODE(1'b0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    pc_incrementer #(.WIDTH(32), .STEP(4), .RESET_VAL(32'h0), .SAT_MODE(1'b1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [65:0] pack(input logic [31:0] p, input logic w, input logic s);
        logic [31:0] plus;
        plus = p + 32'd4;
        return {p, plus, w, s};
    endfunction

    // driver: apply controls for the next edge and queue what each instance must show after it
    task automatic drive(input logic rst, input logic st, input logic sk, input logic ld,
                         input logic [31:0] addr,
                         input logic [31:0] pc0, input logic w0, input logic s0,
                         input logic [31:0] pc1, input logic w1, input logic s1);
        reset     = rst;
        stall     = st;
        skip      = sk;
        load      = ld;
        load_addr = addr;
        exp0_q.push_back(pack(pc0, w0, s0));
        exp1_q.push_back(pack(pc1, w1, s1));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1:    drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
                2:       drive(0, 0, 0, 0, 32'h0, 32'h4, 0, 0, 32'h4, 0, 0);
                default: drive(0, 0, 0, 0, 32'h0, 32'h8, 0, 0, 32'h8, 0, 0);
            endcase
            tick();
            o0 = {bus0.pc, bus0.pc_plus, bus0.wrap, bus0.sat};
            o1 = {bus1.pc, bus1.pc_plus, bus1.wrap, bus1.sat};
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            n_cmp += 2;
            if (o0 !== e0) begin n_fail++; $display("FAIL reset step %0d wrap-dut got %h want %h", i, o0, e0); end
            if (o1 !== e1) begin n_fail++; $display("FAIL reset step %0d sat-dut got %h want %h", i, o1, e1); end
        end
    endtask

    task automatic test_stall_load();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0, 1, 2: drive(0, 1, 0, 0, 32'h0,   32'h8,   0, 0, 32'h8,   0, 0);
                3:       drive(0, 1, 0, 1, 32'h100, 32'h100, 0, 0, 32'h100, 0, 0);
                default: drive(0, 0, 0, 0, 32'h0,   32'h104, 0, 0, 32'h104, 0, 0);
            endcase
            tick();
            o0 = {bus0.pc, bus0.pc_plus, bus0.wrap, bus0.sat};
            o1 = {bus1.pc, bus1.pc_plus, bus1.wrap, bus1.sat};
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            n_cmp += 2;
            if (o0 !== e0) begin n_fail++; $display("FAIL stall_load step %0d wrap-dut got %h want %h", i, o0, e0); end
            if (o1 !== e1) begin n_fail++; $display("FAIL stall_load step %0d sat-dut got %h want %h", i, o1, e1); end
        end
    endtask

    task automatic test_skip();
        for (int i = 0; i < 2; i++) begin
            case (i)
                0:       drive(0, 0, 1, 0, 32'h0, 32'h10C, 0, 0, 32'h10C, 0, 0);
                default: drive(0, 1, 1, 0, 32'h0, 32'h10C, 0, 0, 32'h10C, 0, 0);
            endcase
            tick();
            o0 = {bus0.pc, bus0.pc_plus, bus0.wrap, bus0.sat};
            o1 = {bus1.pc, bus1.pc_plus, bus1.wrap, bus1.sat};
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            n_cmp += 2;
            if (o0 !== e0) begin n_fail++; $display("FAIL skip step %0d wrap-dut got %h want %h", i, o0, e0); end
            if (o1 !== e1) begin n_fail++; $display("FAIL skip step %0d sat-dut got %h want %h", i, o1, e1); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: drive(0, 0, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 0, 0);
                1: drive(0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0);
                2: drive(0, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 32'hFFFF_FFFC, 1, 1);
                3: drive(0, 0, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 32'hFFFF_FFFC, 0, 1);
                4: drive(0, 1, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 32'hFFFF_FFFC, 0, 1);
                5: drive(0, 0, 1, 0, 32'h0,         32'h0000_000C, 0, 0, 32'hFFFF_FFFC, 0, 1);
                6: drive(0, 1, 1, 1, 32'h40,        32'h0000_0040, 0, 0, 32'h0000_0040, 0, 0);
                default: drive(0, 0, 0, 0, 32'h0,   32'h0000_0044, 0, 0, 32'h0000_0044, 0, 0);
            endcase
            tick();
            o0 = {bus0.pc, bus0.pc_plus, bus0.wrap, bus0.sat};
            o1 = {bus1.pc, bus1.pc_plus, bus1.wrap, bus1.sat};
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            n_cmp += 2;
            if (o0 !== e0) begin n_fail++; $display("FAIL overflow step %0d wrap-dut got %h want %h", i, o0, e0); end
            if (o1 !== e1) begin n_fail++; $display("FAIL overflow step %0d sat-dut got %h want %h", i, o1, e1); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(0, 0, 0, 1, 32'h123,       32'h0000_0123, 0, 0, 32'h0000_0123, 0, 0);
                1: drive(0, 0, 1, 1, 32'h200,       32'h0000_0200, 0, 0, 32'h0000_0200, 0, 0);
                2: drive(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0);
                default: drive(0, 0, 1, 0, 32'h0,   32'h0000_0004, 1, 0, 32'hFFFF_FFFC, 1, 1);
            endcase
            tick();
            o0 = {bus0.pc, bus0.pc_plus, bus0.wrap, bus0.sat};
            o1 = {bus1.pc, bus1.pc_plus, bus1.wrap, bus1.sat};
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            n_cmp += 2;
            if (o0 !== e0) begin n_fail++; $display("FAIL back_to_back step %0d wrap-dut got %h want %h", i, o0, e0); end
            if (o1 !== e1) begin n_fail++; $display("FAIL back_to_back step %0d sat-dut got %h want %h", i, o1, e1); end
        end
    endtask

    task automatic test_reset_priority();
        for (int i = 0; i < 2; i++) begin
            case (i)
                0:       drive(1, 1, 1, 1, 32'h80, 32'h0, 0, 0, 32'h0, 0, 0);
                default: drive(0, 0, 0, 0, 32'h0,  32'h4, 0, 0, 32'h4, 0, 0);
            endcase
            tick();
            o0 = {bus0.pc, bus0.pc_plus, bus0.wrap, bus0.sat};
            o1 = {bus1.pc, bus1.pc_plus, bus1.wrap, bus1.sat};
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            n_cmp += 2;
            if (o0 !== e0) begin n_fail++; $display("FAIL reset_priority step %0d wrap-dut got %h want %h", i, o0, e0); end
            if (o1 !== e1) begin n_fail++; $display("FAIL reset_priority step %0d sat-dut got %h want %h", i, o1, e1); end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic        sk;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                addr = $urandom_range(32'h0FFF_FFFF, 0) & 32'hFFFF_FFFC;
                drive(0, 0, $urandom_range(1, 0), 1, addr, addr, 0, 0, addr, 0, 0);
            end else begin
                sk = 1'($urandom_range(1, 0));
                drive(0, 0, sk, 0, 32'h0, addr + (sk ? 32'd8 : 32'd4), 0, 0,
                      addr + (sk ? 32'd8 : 32'd4), 0, 0);
            end
            tick();
            o0 = {bus0.pc, bus0.pc_plus, bus0.wrap, bus0.sat};
            o1 = {bus1.pc, bus1.pc_plus, bus1.wrap, bus1.sat};
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            n_cmp += 2;
            if (o0 !== e0) begin n_fail++; $display("FAIL random step %0d wrap-dut got %h want %h", i, o0, e0); end
            if (o1 !== e1) begin n_fail++; $display("FAIL random step %0d sat-dut got %h want %h", i, o1, e1); end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        skip      = 1'b0;
        load      = 1'b0;
        load_addr = 32'h0;
        @(negedge clk);
        test_reset();
        test_stall_load();
        test_skip();
        test_overflow();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
